// File: rtl/pc_trace_logger.sv
// Instruction trace logger: captures {pc, inst} pairs into a FIFO and streams
// each entry out as two 32-bit words (pc then inst) over valid/ready.
module pc_trace_logger #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       inst_in,
  output logic [31:0]       out_data,
  output logic              out_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [15:0]       drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SEND_PC,
    SEND_INST
  } state_t;

  state_t             state, state_nx;
  logic [31:0]        pc_mem   [DEPTH];
  logic [31:0]        inst_mem [DEPTH];
  logic [ADDR_W-1:0]  wptr, rptr, rptr_inc;
  logic               full, pop, wr, drop;
  logic [31:0]        next_pc;
  logic [31:0]        data_nx;
  logic               tag_nx, valid_nx;
  logic [ADDR_W:0]    count_nx;

  assign full     = (count == (ADDR_W+1)'(DEPTH));
  assign pop      = (state == SEND_INST) && out_valid && out_ready;
  assign wr       = en && (!full || pop);
  assign drop     = en && full && !pop;
  assign rptr_inc = rptr + ADDR_W'(1);

  // With only the popped entry stored, the next head is the pair being
  // written at this same edge, so bypass it from the inputs.
  assign next_pc = (count > (ADDR_W+1)'(1)) ? pc_mem[rptr_inc] : pc_in;

  always_ff @(posedge clk) begin
    if (wr) begin
      pc_mem[wptr]   <= pc_in;
      inst_mem[wptr] <= inst_in;
    end
  end

  always_comb begin
    state_nx = state;
    data_nx  = out_data;
    tag_nx   = out_tag;
    valid_nx = out_valid;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          state_nx = SEND_PC;
          data_nx  = pc_mem[rptr];
          tag_nx   = 1'b0;
          valid_nx = 1'b1;
        end else begin
          valid_nx = 1'b0;
        end
      end
      SEND_PC: begin
        if (out_ready) begin
          state_nx = SEND_INST;
          data_nx  = inst_mem[rptr];
          tag_nx   = 1'b1;
        end
      end
      SEND_INST: begin
        if (pop) begin
          if (count > (ADDR_W+1)'(1) || wr) begin
            state_nx = SEND_PC;
            data_nx  = next_pc;
            tag_nx   = 1'b0;
            valid_nx = 1'b1;
          end else begin
            state_nx = IDLE;
            valid_nx = 1'b0;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
    endcase
  end

  always_comb begin
    count_nx = count;
    case ({wr, pop})
      2'b10:   count_nx = count + (ADDR_W+1)'(1);
      2'b01:   count_nx = count - (ADDR_W+1)'(1);
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_data  <= '0;
      out_tag   <= 1'b0;
      out_valid <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_nx;
      out_data  <= data_nx;
      out_tag   <= tag_nx;
      out_valid <= valid_nx;
      count     <= count_nx;
      if (wr) wptr <= wptr + ADDR_W'(1);
      if (pop) rptr <= rptr_inc;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_trace_logger.sv
// Bench for pc_trace_logger: directed and random captures checked every cycle
// against a queue-based model of the logger and its word stream.
module tb_pc_trace_logger;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [31:0]       pc_in, inst_in;
  logic [31:0]       out_data;
  logic              out_tag, out_valid, out_ready;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic [15:0]       drop_cnt;

  pc_trace_logger #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .en(en), .pc_in(pc_in), .inst_in(inst_in),
    .out_data(out_data), .out_tag(out_tag), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] expq[$];
  logic [31:0] rxq[$];
  int          phase;   // 0 idle, 1 head pc on output, 2 head inst on output
  int          m_drops;
  bit          m_ovf;
  int          compared = 0;
  int          mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(mq.size()));
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, "_drops"}, 32'(drop_cnt), 32'(m_drops));
    chk({tag, "_valid"}, 32'(out_valid), 32'(phase != 0));
    if (phase == 1) begin
      chk({tag, "_data"}, out_data, mq[0].pc);
      chk({tag, "_tag"}, 32'(out_tag), 32'd0);
    end else if (phase == 2) begin
      chk({tag, "_data"}, out_data, mq[0].inst);
      chk({tag, "_tag"}, 32'(out_tag), 32'd1);
    end
  endtask

  task automatic model_edge(input bit e, input logic [31:0] p, input logic [31:0] i, input bit r);
    bit pop, full, w;
    pop  = (phase == 2) && r;
    full = (mq.size() == DEPTH);
    w    = e && (!full || pop);
    if (e && !w) begin
      m_ovf = 1'b1;
      if (m_drops < 65535) m_drops++;
    end
    if (phase != 0 && r) expq.push_back(phase == 1 ? mq[0].pc : mq[0].inst);
    case (phase)
      0: if (mq.size() > 0) phase = 1;
      1: if (r) phase = 2;
      default: if (r) begin
        void'(mq.pop_front());
        phase = (mq.size() > 0 || w) ? 1 : 0;
      end
    endcase
    if (w) mq.push_back('{p, i});
  endtask

  task automatic step(input string tag, input bit e, input logic [31:0] p,
                      input logic [31:0] i, input bit r);
    @(negedge clk);
    en = e; pc_in = p; inst_in = i; out_ready = r;
    #1;
    if (out_valid && out_ready) rxq.push_back(out_data);
    @(posedge clk);
    model_edge(e, p, i, r);
    #1 check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1; en = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    mq.delete(); expq.delete(); rxq.delete();
    phase = 0; m_drops = 0; m_ovf = 1'b0;
    #1;
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_drops"}, 32'(drop_cnt), 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_tag"}, 32'(out_tag), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic compare_streams(input string tag);
    chk({tag, "_nwords"}, 32'(rxq.size()), 32'(expq.size()));
    for (int k = 0; k < expq.size() && k < rxq.size(); k++)
      chk({tag, "_word"}, rxq[k], expq[k]);
    rxq.delete(); expq.delete();
  endtask

  initial begin
    int caps;
    bit e;
    reset = 1'b1; en = 1'b0; pc_in = '0; inst_in = '0; out_ready = 1'b0;
    phase = 0; m_drops = 0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    do_reset("rst0");

    // Single capture, streamed straight out.
    step("t1", 1'b1, 32'h00400000, 32'h3C011001, 1'b1);
    repeat (4) step("t1i", 1'b0, '0, '0, 1'b1);
    chk("t1_w0", rxq[0], 32'h00400000);
    chk("t1_w1", rxq[1], 32'h3C011001);
    chk("t1_cnt_end", 32'(count), 32'd0);
    chk("t1_valid_end", 32'(out_valid), 32'd0);
    compare_streams("t1");

    // Back-to-back captures, no bubble between entries.
    for (int k = 0; k < 4; k++)
      step("t2", 1'b1, 32'h00400000 + 32'(4 * k), $urandom, 1'b1);
    repeat (8) step("t2i", 1'b0, '0, '0, 1'b1);
    chk("t2_ovf", 32'(overflow), 32'd0);
    compare_streams("t2");

    // Stalled sink fills the FIFO and drops the rest.
    for (int k = 0; k < 20; k++)
      step("t3", 1'b1, 32'h00001000 + 32'(4 * k), $urandom, 1'b0);
    chk("t3_count", 32'(count), 32'd16);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_drops", 32'(drop_cnt), 32'd4);
    chk("t3_head", out_data, 32'h00001000);

    // Full FIFO: pop and write at the same edge.
    step("t4a", 1'b0, '0, '0, 1'b1);
    step("t4b", 1'b1, 32'hBEEF0000, 32'h0BADF00D, 1'b1);
    chk("t4_count", 32'(count), 32'd16);
    chk("t4_drops", 32'(drop_cnt), 32'd4);
    repeat (40) step("t4d", 1'b0, '0, '0, 1'b1);
    compare_streams("t4");

    // Random captures against a randomly stalling sink.
    caps = 0;
    while (caps < 100) begin
      e = 1'($urandom % 2);
      step("t5", e, $urandom, $urandom, 1'($urandom % 2));
      if (e) caps++;
    end
    repeat (40) step("t5d", 1'b0, '0, '0, 1'b1);
    chk("t5_empty", 32'(count), 32'd0);
    compare_streams("t5");

    // Reset while mid-entry in SEND_INST.
    for (int k = 0; k < 5; k++)
      step("t6f", 1'b1, 32'h00002000 + 32'(4 * k), $urandom, 1'b0);
    step("t6s", 1'b0, '0, '0, 1'b1);
    chk("t6_pre_count", 32'(count), 32'd5);
    chk("t6_pre_tag", 32'(out_tag), 32'd1);
    do_reset("t6rst");
    step("t6c", 1'b1, 32'hCAFE0000, 32'h12345678, 1'b1);
    repeat (4) step("t6i", 1'b0, '0, '0, 1'b1);
    chk("t6_first", rxq[0], 32'hCAFE0000);
    compare_streams("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pc_trace_logger.md
Name: pc_trace_logger

Overview:
- Consumer end of the CPU's observation interface: samples the per-cycle `pc`/`inst` pair from the top-level dataflow CPU into a FIFO.
- Drains each captured entry as two 32-bit words (pc, then inst) over a valid/ready stream toward a UART or trace sink.
- Replaces waveform inspection of `inst`/`pc` with a hardware-checkable instruction trace; reports loss when the sink stalls.

Parameters:
DEPTH, 16, FIFO entries (power of 2, ≥2)
ADDR_W, 4, log2(DEPTH)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  capture enable; sample pc_in/inst_in this cycle
pc_in  input  32  CPU program counter
inst_in  input  32  CPU instruction at pc_in
out_data  output  32  stream word
out_tag  output  1  0 = word is pc, 1 = word is inst
out_valid  output  1  out_data/out_tag valid
out_ready  input  1  sink accepts word this cycle
count  output  ADDR_W+1  FIFO occupancy, 0..DEPTH
overflow  output  1  sticky: at least one capture dropped
drop_cnt  output  16  dropped captures, saturates at 16'hFFFF

Behaviour:
- Single clock. Reset is synchronous and active-high; ports are named `clk` and `reset`.
- Reset values:
  - out_data=0, out_tag=0, out_valid=0.
  - count=0, overflow=0, drop_cnt=0.
  - FSM=IDLE; read and write pointers=0.
- Reset mid-transfer discards all FIFO contents and any partially sent entry. No word is completed after reset.
- Write side:
  - At an edge with en=1, the pair {pc_in, inst_in} is written at wptr if the FIFO is not full, or if a pop occurs at that same edge. wptr then increments modulo DEPTH.
  - Otherwise (en=1, full, no pop), the capture is dropped: overflow←1 and drop_cnt←drop_cnt+1, saturating.
  - en=0: no write, no drop.
- count: +1 on write only, −1 on pop only, unchanged on write+pop at the same edge. It never exceeds DEPTH.
- Pop: occurs exactly at an edge where state=SEND_INST, out_valid=1 and out_ready=1. rptr increments modulo DEPTH.
- FSM:
  - IDLE: if count>0, go to SEND_PC. Load out_data=head.pc, out_tag=0, out_valid=1. Otherwise stay, with out_valid=0.
  - SEND_PC: on out_ready=1, go to SEND_INST. Load out_data=head.inst, out_tag=1. While out_ready=0, hold all outputs stable.
  - SEND_INST: on out_ready=1, pop.
    - If entries remain after the pop (count−1>0), or a write occurs at the same edge, go to SEND_PC and load the next head's pc, keeping out_valid=1. There is no bubble.
    - Otherwise go to IDLE with out_valid=0.
    - While out_ready=0, hold.
- Latency: a capture at edge k into an empty idle logger gives out_valid=1 with its pc after edge k+1. Sustained throughput is 1 entry per 2 cycles.
- out_data and out_tag never change while out_valid=1 and out_ready=0.
- The head entry is read combinationally from FIFO storage at rptr. A write to a non-head slot never disturbs it.
- Pointer wrap is natural modulo DEPTH. full ≡ count==DEPTH; empty ≡ count==0.

Test Plan:
1. Reset, en=1 for one cycle with pc_in=32'h00400000, inst_in=32'h3C011001, out_ready=1 → words 00400000 (tag 0), then 3C011001 (tag 1) on consecutive cycles; count returns to 0; out_valid=0 afterward.
2. en=1 for 4 cycles with pc=00400000+4i, out_ready=1 → 8 words in order, alternating tags, with no bubble between entries; overflow=0.
3. out_ready=0, en=1 for 20 cycles (DEPTH=16) → count saturates at 16, overflow=1, drop_cnt=4 (one entry is held as the head in SEND_PC). out_data stays at the first pc throughout.
4. FIFO full, state SEND_INST, out_ready=1 and en=1 at the same edge → write accepted, count stays 16, drop_cnt unchanged.
5. Random out_ready toggling over 100 captures at 50% rate → the received (pc, inst) sequence equals the captured sequence minus the counted drops; words stay stable during stalls.
6. Reset asserted while in SEND_INST with count=5 → next cycle count=0, out_valid=0, overflow=0, drop_cnt=0; a new capture after reset emits its own pc first.
